xmodem_pkt_writer: RTL and testbench
====================================

XMODEM_PKT_WRITER -- requirements
Module: xmodem_pkt_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of the first payload word written to memory.
REQ-002 The block SHALL have parameter PKT_BYTES, default 128, the XMODEM payload size; it is fixed at a multiple of 4.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a pulse that begins a new transfer.
REQ-006 The block SHALL have port byte_valid, input, 1 bit, qualifying byte_data from the xmodem decoder.
REQ-007 The block SHALL have port byte_data, input, 8 bits, the payload byte.
REQ-008 The block SHALL have port byte_ready, output, 1 bit; a byte is accepted when byte_valid and byte_ready are both high.
REQ-009 The block SHALL have port pkt_commit, input, 1 bit, a pulse meaning checksum good and packet number new.
REQ-010 The block SHALL have port pkt_abort, input, 1 bit, a pulse meaning bad checksum or duplicate, so the buffer is discarded.
REQ-011 The block SHALL have port xfer_done, input, 1 bit, a pulse meaning EOT was received.
REQ-012 The block SHALL have port mem_req, output, 1 bit, a write request held until acknowledged.
REQ-013 The block SHALL have port mem_addr, output, 32 bits, the byte address, word-aligned.
REQ-014 The block SHALL have port mem_wdata, output, 32 bits, the write data.
REQ-015 The block SHALL have port mem_ack, input, 1 bit, a one-cycle write acknowledge.
REQ-016 The block SHALL have port busy, output, 1 bit, high in the FILL and WRITE states.
REQ-017 The block SHALL have port done, output, 1 bit, high in the DONE state.
REQ-018 The block SHALL have port pkt_count, output, 8 bits, the number of committed packets (wraps).
REQ-019 The block SHALL have port err, output, 1 bit, a sticky protocol error flag.

Function
REQ-020 The block SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-021 In IDLE, a start pulse SHALL move the block to FILL, set the write pointer to BASE_ADDR, and clear byte count, pkt_count and err.
REQ-022 In DONE, a start pulse SHALL behave identically to REQ-021.
REQ-023 In FILL, byte_ready SHALL equal (byte_count < PKT_BYTES).
REQ-024 In FILL, each accepted byte SHALL be stored into a PKT_BYTES/4-word staging buffer, little-endian (byte k goes to word k/4, bits 8*(k%4)+7:8*(k%4)), and SHALL increment byte_count.
REQ-025 byte_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-026 A pkt_commit in FILL with byte_count==PKT_BYTES SHALL move the block to WRITE with word index 0.
REQ-027 A pkt_commit in FILL with byte_count!=PKT_BYTES SHALL set err, discard the buffer (byte_count=0) and keep the block in FILL.
REQ-028 A pkt_abort in FILL SHALL set byte_count=0 and keep the block in FILL, with err unchanged.
REQ-029 If pkt_abort and pkt_commit arrive in the same cycle, abort SHALL win.
REQ-030 If pkt_abort coincides with an accepted byte, the byte SHALL be dropped and byte_count SHALL be 0.
REQ-031 In WRITE, mem_req SHALL be 1, with mem_addr=wptr+4*idx and mem_wdata=buffer[idx], all held stable until mem_ack.
REQ-032 On each mem_ack in WRITE, idx SHALL increment.
REQ-033 On the mem_ack for the last word, the block SHALL deassert mem_req on the next cycle, set wptr+=PKT_BYTES, increment pkt_count, set byte_count=0 and return to FILL.
REQ-034 The block SHALL allow back-to-back words: mem_req stays high across consecutive acks, one word per ack.
REQ-035 The minimum commit-to-FILL latency SHALL be 1+PKT_BYTES/4 cycles, with mem_ack tied high.
REQ-036 pkt_commit, pkt_abort or xfer_done arriving in WRITE SHALL be ignored and SHALL set err; the write-out completes normally.
REQ-037 xfer_done in FILL SHALL move the block to DONE; a partial, uncommitted buffer is discarded and err is unchanged.
REQ-038 start in FILL or WRITE SHALL be ignored.
REQ-039 mem_ack outside WRITE SHALL be ignored.
REQ-040 The write pointer SHALL be 32 bits and wrap modulo 2^32.
REQ-041 pkt_count SHALL wrap from 255 to 0.

Reset
REQ-042 When rstn is low, the block SHALL asynchronously force state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, byte_ready=0, busy=0, done=0, pkt_count=0, err=0, byte_count=0, idx=0 and wptr=BASE_ADDR.
REQ-043 Staging buffer contents SHALL NOT be reset.
REQ-044 Reset asserted mid-WRITE SHALL abandon the packet immediately, with mem_req low in the same cycle.

Verification
REQ-045 The bench SHALL cover: start; 128 bytes with values 0x00..0x7F; commit; mem_ack always high -> 32 writes, first at addr 0x0 with data 0x03020100, last at 0x7C with data 0x7F7E7D7C; then pkt_count=1 and busy=1.
REQ-046 The bench SHALL cover: two committed packets, then xfer_done -> second packet writes to 0x80..0xFC; done=1; pkt_count=2; err=0.
REQ-047 The bench SHALL cover: 128 bytes, then pkt_abort, then 128 bytes of 0xAA, then commit -> all 32 words are 0xAAAAAAAA at 0x00..0x7C; pkt_count=1.
REQ-048 The bench SHALL cover: commit after 100 bytes -> err=1, no mem_req, byte_count=0.
REQ-049 The bench SHALL cover: mem_ack delayed by 3 cycles per word -> mem_addr and mem_wdata stable while mem_req is high; a commit pulse during WRITE -> err=1 and all 32 writes still complete.
REQ-050 The bench SHALL cover: rstn low during WRITE at word 10 -> mem_req=0 immediately; after release and start, the first write goes to BASE_ADDR.

Source files
------------

// File: rtl/xmodem_pkt_writer.sv
// rtl/xmodem_pkt_writer.sv - stages XMODEM payload bytes and writes committed packets to memory
// Bytes fill a word buffer; a valid commit drains it as word writes, one per mem_ack.
module xmodem_pkt_writer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned PKT_BYTES = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic        pkt_commit,
   input  logic        pkt_abort,
   input  logic        xfer_done,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic [7:0]  pkt_count,
   output logic        err
);
   localparam int unsigned WORDS = PKT_BYTES / 4;
   localparam int unsigned CW    = $clog2(PKT_BYTES + 1);
   localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] FULL = CW'(PKT_BYTES);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [31:0]    wptr_q, wptr_d;
   logic [7:0]     pkt_q, pkt_d;
   logic           err_q, err_d;
   logic           mem_req_q, mem_req_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [31:0]    stage_q [WORDS];
   logic           stage_we;
   logic [IW-1:0]  widx;
   logic [1:0]     bsel;
   logic [IW-1:0]  idx_next;
   logic           accept;

   assign widx     = IW'(count_q >> 2);
   assign bsel     = count_q[1:0];
   assign idx_next = idx_q + IW'(1);
   assign accept   = byte_valid && ready_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      idx_d       = idx_q;
      wptr_d      = wptr_q;
      pkt_d       = pkt_q;
      err_d       = err_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      stage_we    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FILL;
               wptr_d  = BASE_ADDR;
               count_d = '0;
               idx_d   = '0;
               pkt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_FILL: begin
            // abort dominates both a coincident commit and a coincident byte
            if (pkt_abort) begin
               count_d = '0;
            end else if (pkt_commit) begin
               if (count_q == FULL) begin
                  state_d     = S_WRITE;
                  idx_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = wptr_q;
                  mem_wdata_d = stage_q[0];
               end else begin
                  err_d   = 1'b1;
                  count_d = '0;
               end
            end else if (xfer_done) begin
               state_d = S_DONE;
               count_d = '0;
            end else if (accept) begin
               stage_we = 1'b1;
               count_d  = count_q + CW'(1);
            end
         end
         S_WRITE: begin
            if (pkt_commit || pkt_abort || xfer_done) err_d = 1'b1;
            if (mem_ack) begin
               if (idx_q == LAST) begin
                  state_d   = S_FILL;
                  mem_req_d = 1'b0;
                  wptr_d    = wptr_q + 32'(PKT_BYTES);
                  pkt_d     = pkt_q + 8'd1;
                  count_d   = '0;
                  idx_d     = '0;
               end else begin
                  idx_d       = idx_next;
                  mem_addr_d  = wptr_q + 32'({idx_next, 2'b00});
                  mem_wdata_d = stage_q[idx_next];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_FILL) && (count_d < FULL);
      busy_d  = (state_d == S_FILL) || (state_d == S_WRITE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         idx_q       <= '0;
         wptr_q      <= BASE_ADDR;
         pkt_q       <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         wptr_q      <= wptr_d;
         pkt_q       <= pkt_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // staging buffer holds payload only; it is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (stage_we) stage_q[widx][{bsel, 3'b000} +: 8] <= byte_data;
   end

   assign byte_ready = ready_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pkt_count  = pkt_q;
   assign err        = err_q;
endmodule

// File: tb/tb_xmodem_pkt_writer.sv
// tb/tb_xmodem_pkt_writer.sv - self-checking bench for xmodem_pkt_writer
module tb_xmodem_pkt_writer;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int PB = 128;
   localparam int NW = PB / 4;

   logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, byte_valid = 1'b0;
   logic        pkt_commit = 1'b0, pkt_abort = 1'b0, xfer_done = 1'b0, mem_ack = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, mem_req, busy, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [7:0]  pkt_count;

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;
   int ack_wait = 0;
   logic [63:0] wr_q[$];
   logic [63:0] exp_q[$];
   logic [7:0]  pkt_buf [PB];
   logic        prev_pending = 1'b0;
   logic [31:0] prev_a = 32'h0, prev_d = 32'h0;

   typedef struct {
      int         nbytes;
      logic [3:0] ev;
      logic       e_req, e_busy, e_done, e_ready, e_err;
      string      name;
   } vec_t;
   vec_t vt [8];

   xmodem_pkt_writer #(.BASE_ADDR(BASE), .PKT_BYTES(PB)) dut (
      .clk(clk), .rstn(rstn), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .pkt_commit(pkt_commit), .pkt_abort(pkt_abort), .xfer_done(xfer_done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .busy(busy), .done(done), .pkt_count(pkt_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout", name);
   endtask

   // memory responder: ack after ack_delay idle cycles; tied high when ack_delay is 0
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) ack_wait = 0;
         if (mem_req) begin
            if (ack_wait >= ack_delay) mem_ack = 1'b1;
            else begin
               mem_ack = 1'b0;
               ack_wait++;
            end
         end else begin
            mem_ack  = (ack_delay == 0);
            ack_wait = 0;
         end
      end
   end

   // write monitor and hold-stability checker
   always @(negedge clk) begin
      if (rstn && mem_req && mem_ack) wr_q.push_back({mem_addr, mem_wdata});
      if (rstn && mem_req && prev_pending) begin
         check("hold_addr", 64'(mem_addr), 64'(prev_a));
         check("hold_data", 64'(mem_wdata), 64'(prev_d));
      end
      prev_pending = rstn && mem_req && !mem_ack;
      prev_a = mem_addr;
      prev_d = mem_wdata;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      {start, pkt_commit, pkt_abort, xfer_done, byte_valid} = 5'b0;
      tick(2);
      rstn = 1'b1;
      tick(1);
      wr_q.delete();
      exp_q.delete();
   endtask

   // bits: {start, commit, abort, xfer_done}
   task automatic pulse(input logic [3:0] m);
      {start, pkt_commit, pkt_abort, xfer_done} = m;
      tick(1);
      {start, pkt_commit, pkt_abort, xfer_done} = 4'b0;
   endtask

   task automatic wait_fill();
      int n = 0;
      while (!(busy && !mem_req) && n < 2000) begin
         tick(1);
         n++;
      end
      if (n >= 2000) timeout("wait_fill");
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      if (gap) tick($urandom_range(0, 2));
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 2000) begin
         tick(1);
         n++;
      end
      if (n >= 2000) timeout("send_byte");
      tick(1);
      byte_valid = 1'b0;
   endtask

   // mode 0: k, 1: 0xAA, 2: random
   task automatic send_bytes(input int n, input int mode, input bit gap);
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         b = (mode == 0) ? 8'(k) : (mode == 1) ? 8'hAA : 8'($urandom);
         pkt_buf[k] = b;
         send_byte(b, gap);
      end
   endtask

   // reference: word w is bytes 4w..4w+3 little-endian at wp + 4w
   task automatic expect_pkt(input logic [31:0] wp);
      for (int w = 0; w < NW; w++)
         exp_q.push_back({wp + 32'(4 * w), pkt_buf[4*w+3], pkt_buf[4*w+2], pkt_buf[4*w+1], pkt_buf[4*w]});
   endtask

   task automatic compare_writes(input string name);
      check({name, ".nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check($sformatf("%s.wr%0d", name, i), wr_q[i], exp_q[i]);
      wr_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vt[0] = '{128, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "commit_full"};
      vt[1] = '{100, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "commit_short"};
      vt[2] = '{128, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "abort_full"};
      vt[3] = '{128, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "abort_beats_commit"};
      vt[4] = '{50,  4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "xfer_in_fill"};
      vt[5] = '{0,   4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "commit_empty"};
      vt[6] = '{127, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "commit_127"};
      vt[7] = '{10,  4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "start_in_fill"};

      // reset state
      tick(1);
      check("rst.mem_req", 64'(mem_req), 64'(0));
      check("rst.mem_addr", 64'(mem_addr), 64'(0));
      check("rst.mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst.byte_ready", 64'(byte_ready), 64'(0));
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.done", 64'(done), 64'(0));
      check("rst.pkt_count", 64'(pkt_count), 64'(0));
      check("rst.err", 64'(err), 64'(0));
      rstn = 1'b1;

      // single-event reactions from FILL
      for (int i = 0; i < 8; i++) begin
         do_reset();
         ack_delay = 0;
         pulse(4'b1000);
         send_bytes(vt[i].nbytes, 2, 1'b0);
         pulse(vt[i].ev);
         check({vt[i].name, ".mem_req"}, 64'(mem_req), 64'(vt[i].e_req));
         check({vt[i].name, ".busy"}, 64'(busy), 64'(vt[i].e_busy));
         check({vt[i].name, ".done"}, 64'(done), 64'(vt[i].e_done));
         check({vt[i].name, ".byte_ready"}, 64'(byte_ready), 64'(vt[i].e_ready));
         check({vt[i].name, ".err"}, 64'(err), 64'(vt[i].e_err));
      end

      // incrementing packet, ack tied high, commit-to-FILL latency
      do_reset();
      pulse(4'b1000);
      send_bytes(PB, 0, 1'b0);
      check("s1.ready_when_full", 64'(byte_ready), 64'(0));
      pulse(4'b0100);
      expect_pkt(BASE);
      n = 0;
      while (mem_req && n < 200) begin
         tick(1);
         n++;
      end
      check("s1.write_cycles", 64'(n), 64'(NW));
      check("s1.first", (wr_q.size() > 0) ? wr_q[0] : 64'hx, {BASE, 32'h03020100});
      check("s1.last", (wr_q.size() >= NW) ? wr_q[NW-1] : 64'hx, {BASE + 32'h7C, 32'h7F7E7D7C});
      check("s1.pkt_count", 64'(pkt_count), 64'(1));
      check("s1.busy", 64'(busy), 64'(1));
      compare_writes("s1");

      // two packets then EOT
      do_reset();
      pulse(4'b1000);
      send_bytes(PB, 0, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      wait_fill();
      send_bytes(PB, 2, 1'b1);
      pulse(4'b0100);
      expect_pkt(BASE + 32'(PB));
      wait_fill();
      pulse(4'b0001);
      check("s2.done", 64'(done), 64'(1));
      check("s2.busy", 64'(busy), 64'(0));
      check("s2.pkt_count", 64'(pkt_count), 64'(2));
      check("s2.err", 64'(err), 64'(0));
      compare_writes("s2");

      // abort discards, next packet of 0xAA lands at base
      do_reset();
      pulse(4'b1000);
      send_bytes(PB, 2, 1'b0);
      pulse(4'b0010);
      send_bytes(PB, 1, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      wait_fill();
      check("s3.pkt_count", 64'(pkt_count), 64'(1));
      check("s3.err", 64'(err), 64'(0));
      compare_writes("s3");

      // short commit: error, no writes, count restarts from zero
      do_reset();
      pulse(4'b1000);
      send_bytes(100, 2, 1'b0);
      pulse(4'b0100);
      check("s4.err", 64'(err), 64'(1));
      tick(3);
      check("s4.mem_req", 64'(mem_req), 64'(0));
      check("s4.nwrites", 64'(wr_q.size()), 64'(0));
      check("s4.byte_ready", 64'(byte_ready), 64'(1));
      send_bytes(PB, 2, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      wait_fill();
      check("s4.pkt_count", 64'(pkt_count), 64'(1));
      compare_writes("s4");

      // slow acks and a stray commit while writing
      do_reset();
      ack_delay = 3;
      pulse(4'b1000);
      send_bytes(PB, 2, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      tick(20);
      pulse(4'b0100);
      check("s5.err", 64'(err), 64'(1));
      check("s5.still_writing", 64'(mem_req), 64'(1));
      wait_fill();
      check("s5.pkt_count", 64'(pkt_count), 64'(1));
      compare_writes("s5");
      ack_delay = 0;

      // abort coinciding with an offered byte drops the byte
      do_reset();
      pulse(4'b1000);
      send_bytes(3, 2, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      pkt_abort  = 1'b1;
      tick(1);
      byte_valid = 1'b0;
      pkt_abort  = 1'b0;
      send_bytes(PB, 0, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      wait_fill();
      compare_writes("s6");

      // reset at word 10 of a write-out
      do_reset();
      pulse(4'b1000);
      send_bytes(PB, 2, 1'b0);
      pulse(4'b0100);
      n = 0;
      while (!(mem_req && mem_addr == BASE + 32'd40) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("s7.word10");
      #2 rstn = 1'b0;
      #1;
      check("s7.mem_req", 64'(mem_req), 64'(0));
      check("s7.mem_addr", 64'(mem_addr), 64'(0));
      check("s7.busy", 64'(busy), 64'(0));
      check("s7.pkt_count", 64'(pkt_count), 64'(0));
      tick(2);
      rstn = 1'b1;
      tick(1);
      wr_q.delete();
      exp_q.delete();
      pulse(4'b1000);
      send_bytes(PB, 2, 1'b0);
      pulse(4'b0100);
      expect_pkt(BASE);
      wait_fill();
      compare_writes("s7");

      // randomized transfers against the packet-level model; later rounds restart from DONE
      do_reset();
      for (int r = 0; r < 3; r++) begin
         logic [31:0] wp;
         int pk;
         bit e;
         ack_delay = $urandom_range(0, 2);
         pulse(4'b1000);
         wp = BASE;
         pk = 0;
         e  = 1'b0;
         for (int p = 0; p < 5; p++) begin
            int  nb;
            bit  act;
            nb  = ($urandom_range(0, 2) != 0) ? PB : $urandom_range(0, PB - 1);
            act = ($urandom_range(0, 3) != 0);
            send_bytes(nb, 2, 1'b1);
            wait_fill();
            if (act) begin
               pulse(4'b0100);
               if (nb == PB) begin
                  expect_pkt(wp);
                  wp = wp + 32'(PB);
                  pk++;
               end else e = 1'b1;
            end else pulse(4'b0010);
         end
         wait_fill();
         pulse(4'b0001);
         check($sformatf("rnd%0d.done", r), 64'(done), 64'(1));
         check($sformatf("rnd%0d.pkt_count", r), 64'(pkt_count), 64'(pk));
         check($sformatf("rnd%0d.err", r), 64'(err), 64'(e));
         compare_writes($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
